// File: rtl/reg_wb_arbiter_pkg.sv
// ============================================================================
//  reg_wb_arbiter_pkg : shared CPU constants for register write-back logic
//  Rev 1.0
// ============================================================================
`default_nettype none

package reg_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;
  localparam int CPU_XLEN  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;

endpackage

`default_nettype wire

// File: rtl/reg_wb_arbiter_scoreboard.sv
// ============================================================================
//  reg_scoreboard : busy bit per architectural register, set on issue,
//  cleared on long-latency write-back; set takes precedence.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  reg_idx_t            rd_idx0,
  input  reg_idx_t            rd_idx1,
  output logic                rd_busy0,
  output logic                rd_busy1,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_r;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_en && clr_idx == REG_IDX_W'(i)) busy_nxt[i] = 1'b0;
      // Applied after the clear so a same-cycle reservation survives
      if (set_en && set_idx == REG_IDX_W'(i)) busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_r <= '0;
    else     busy_r <= busy_nxt;
  end

  assign busy     = busy_r;
  assign rd_busy0 = busy_r[rd_idx0];
  assign rd_busy1 = busy_r[rd_idx1];

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// ============================================================================
//  reg_wb_arbiter : two-port register write-back arbiter with anti-starvation
//  for the long-latency port and a RAW/WAW reservation scoreboard.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = CPU_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] writeData,
  output logic            regWrite
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]    starve_cnt;
  logic                force_b;
  logic                iss_fire;
  logic                busy_rs1;
  logic                busy_rs2;
  logic [NUM_REGS-1:0] busy;

  // B overrides A's priority only once it has lost STARVE_LIMIT cycles in a row
  assign force_b   = b_valid && (starve_cnt == LIMIT);
  assign a_ready   = !rst && a_valid && !force_b;
  assign b_ready   = !rst && b_valid && (!a_valid || force_b);
  assign iss_ready = !rst && !busy[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != X0_IDX);
  assign stall     = busy_rs1 | busy_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (b_valid && !b_ready) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd        <= '0;
      writeData <= '0;
      regWrite  <= 1'b0;
    end else if (a_ready) begin
      rd        <= a_rd;
      writeData <= a_data;
      regWrite  <= (a_rd != X0_IDX);
    end else if (b_ready) begin
      rd        <= b_rd;
      writeData <= b_data;
      regWrite  <= (b_rd != X0_IDX);
    end else begin
      regWrite  <= 1'b0;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_fire),
    .set_idx  (iss_rd),
    .clr_en   (b_ready),
    .clr_idx  (b_rd),
    .rd_idx0  (rs1),
    .rd_idx1  (rs2),
    .rd_busy0 (busy_rs1),
    .rd_busy1 (busy_rs2),
    .busy     (busy)
  );

endmodule

`default_nettype wire
